wb_merge: RTL and testbench

- Single-write-port merge stage between the main pipeline writeback and the FPU result buffer; sits directly downstream of the FPU register/issue buffer outputs (RegWrite_fpu, RdW_fpu, ResultW_fpu, PCW_fpu).
- The main pipeline always wins the register-file port. FPU results that cannot be written immediately are queued in a small FIFO.
- Queued FPU results that are superseded by a younger main-pipeline write to the same Rd are killed.
- Supplies pending-Rd lookup for hazard detection and a backpressure flag toward the FPU buffer.

---
 rtl/wb_merge.sv | 189 ++++++++++++++++++
 tb/tb_wb_merge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_merge.sv
`default_nettype none
// ============================================================================
// Module   : wb_merge
// Purpose  : Register-file write-port merge of main writeback and FPU results,
//            with a pending FIFO, kill-on-younger-write and hazard lookup.
//            Optional macro WB_TRACE_EN adds a simulation write/kill trace.
// Revision : 1.0 - initial release
// ============================================================================
module wb_merge #(
  parameter int PC_LEN = 17,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [5:0]        RdW,
  input  logic [31:0]       ResultW,
  input  logic [PC_LEN-3:0] PCW,
  input  logic              RegWrite_fpu,
  input  logic [5:0]        RdW_fpu,
  input  logic [31:0]       ResultW_fpu,
  input  logic [PC_LEN-3:0] PCW_fpu,
  input  logic [5:0]        rs1_q,
  input  logic [5:0]        rs2_q,
  output logic              rf_we,
  output logic [5:0]        rf_rd,
  output logic [31:0]       rf_wd,
  output logic [PC_LEN-3:0] rf_pc,
  output logic              pend_hit1,
  output logic              pend_hit2,
  output logic              fpu_full,
  output logic              overflow
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_FULL_TH = c_CW'(DEPTH - 1);

  logic [5:0]        r_q_rd [DEPTH];
  logic [31:0]       r_q_wd [DEPTH];
  logic [PC_LEN-3:0] r_q_pc [DEPTH];
  logic [DEPTH-1:0]  r_live;
  logic [c_AW-1:0]   r_head;
  logic [c_AW-1:0]   r_tail;
  logic [c_CW-1:0]   r_count;
  logic              r_overflow;
  logic              r_rf_we;
  logic [5:0]        r_rf_rd;
  logic [31:0]       r_rf_wd;
  logic [PC_LEN-3:0] r_rf_pc;

  logic              w_m_v;
  logic              w_f_v;
  logic              w_f_surv;
  logic              w_empty;
  logic              w_full_q;
  logic              w_pop;
  logic              w_direct;
  logic              w_push;
  logic              w_do_push;
  logic              w_drop;
  logic [DEPTH-1:0]  w_kill;
  logic [DEPTH-1:0]  w_hit1;
  logic [DEPTH-1:0]  w_hit2;
  logic [DEPTH-1:0]  w_pop_mask;
  logic [DEPTH-1:0]  w_push_mask;
  logic              w_nx_we;
  logic [5:0]        w_nx_rd;
  logic [31:0]       w_nx_wd;
  logic [PC_LEN-3:0] w_nx_pc;

  assign w_m_v    = RegWriteW & (RdW != 6'd0);
  assign w_f_v    = RegWrite_fpu & (RdW_fpu != 6'd0);
  // An FPU result targeting the same Rd as the concurrent main write is already stale
  assign w_f_surv = w_f_v & ~(w_m_v & (RdW_fpu == RdW));
  assign w_empty  = (r_count == '0);
  assign w_full_q = (r_count == c_DEPTH);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign w_kill[gi] = w_m_v & r_live[gi] & (r_q_rd[gi] == RdW);
      assign w_hit1[gi] = r_live[gi] & (r_q_rd[gi] == rs1_q);
      assign w_hit2[gi] = r_live[gi] & (r_q_rd[gi] == rs2_q);
    end
  endgenerate

  assign pend_hit1 = (rs1_q != 6'd0) & ((|w_hit1) | (w_f_v & (RdW_fpu == rs1_q)));
  assign pend_hit2 = (rs2_q != 6'd0) & ((|w_hit2) | (w_f_v & (RdW_fpu == rs2_q)));

  always_comb begin
    w_nx_we  = 1'b0;
    w_nx_rd  = '0;
    w_nx_wd  = '0;
    w_nx_pc  = '0;
    w_pop    = 1'b0;
    w_direct = 1'b0;
    if (w_m_v) begin
      w_nx_we = 1'b1;
      w_nx_rd = RdW;
      w_nx_wd = ResultW;
      w_nx_pc = PCW;
    end else if (!w_empty) begin
      // Dead heads are popped with no write so the queue keeps moving
      w_pop = 1'b1;
      if (r_live[r_head]) begin
        w_nx_we = 1'b1;
        w_nx_rd = r_q_rd[r_head];
        w_nx_wd = r_q_wd[r_head];
        w_nx_pc = r_q_pc[r_head];
      end
    end else if (w_f_v) begin
      w_direct = 1'b1;
      w_nx_we  = 1'b1;
      w_nx_rd  = RdW_fpu;
      w_nx_wd  = ResultW_fpu;
      w_nx_pc  = PCW_fpu;
    end
  end

  assign w_push      = w_f_surv & ~w_direct;
  assign w_do_push   = w_push & (~w_full_q | w_pop);
  assign w_drop      = w_push & w_full_q & ~w_pop;
  assign w_pop_mask  = w_pop     ? (DEPTH'(1) << r_head) : '0;
  assign w_push_mask = w_do_push ? (DEPTH'(1) << r_tail) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wd    <= '0;
      r_rf_pc    <= '0;
    end else begin
      r_live <= (r_live & ~w_kill & ~w_pop_mask) | w_push_mask;
      if (w_pop)
        r_head <= r_head + c_AW'(1);
      if (w_do_push)
        r_tail <= r_tail + c_AW'(1);
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)
        r_overflow <= 1'b1;
      r_rf_we <= w_nx_we;
      r_rf_rd <= w_nx_rd;
      r_rf_wd <= w_nx_wd;
      r_rf_pc <= w_nx_pc;
    end
  end

  // Payload storage carries no reset; validity is tracked by count and live bits
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_q_rd[r_tail] <= RdW_fpu;
      r_q_wd[r_tail] <= ResultW_fpu;
      r_q_pc[r_tail] <= PCW_fpu;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_rd    = r_rf_rd;
  assign rf_wd    = r_rf_wd;
  assign rf_pc    = r_rf_pc;
  assign fpu_full = (r_count >= c_FULL_TH);
  assign overflow = r_overflow;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (w_nx_we)
        $display("%s%0d <= %h at %h", w_nx_rd[5] ? "f" : "r", w_nx_rd[4:0], w_nx_wd, w_nx_pc);
      for (int i = 0; i < DEPTH; i++)
        if (w_kill[i])
          $display("kill %s%0d at %h", r_q_rd[i][5] ? "f" : "r", r_q_rd[i][4:0], r_q_pc[i]);
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_merge
// Purpose  : Directed self-checking bench for wb_merge (DEPTH=4, PC_LEN=17).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [5:0]  RdW;
  logic [31:0] ResultW;
  logic [14:0] PCW;
  logic        RegWrite_fpu;
  logic [5:0]  RdW_fpu;
  logic [31:0] ResultW_fpu;
  logic [14:0] PCW_fpu;
  logic [5:0]  rs1_q;
  logic [5:0]  rs2_q;
  logic        rf_we;
  logic [5:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [14:0] rf_pc;
  logic        pend_hit1;
  logic        pend_hit2;
  logic        fpu_full;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  wb_merge #(.PC_LEN(17), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .PCW(PCW),
    .RegWrite_fpu(RegWrite_fpu), .RdW_fpu(RdW_fpu), .ResultW_fpu(ResultW_fpu), .PCW_fpu(PCW_fpu),
    .rs1_q(rs1_q), .rs2_q(rs2_q),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .rf_pc(rf_pc),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .fpu_full(fpu_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_main(input logic we, input logic [5:0] rd, input logic [31:0] wd, input logic [14:0] pc);
    RegWriteW = we; RdW = rd; ResultW = wd; PCW = pc;
  endtask

  task automatic set_fpu(input logic we, input logic [5:0] rd, input logic [31:0] wd, input logic [14:0] pc);
    RegWrite_fpu = we; RdW_fpu = rd; ResultW_fpu = wd; PCW_fpu = pc;
  endtask

  task automatic idle();
    set_main(1'b0, 6'd0, 32'd0, 15'd0);
    set_fpu(1'b0, 6'd0, 32'd0, 15'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1_q = 6'd0;
    rs2_q = 6'd0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("reset_we", 64'(rf_we), 64'd0);
    chk("reset_rd", 64'(rf_rd), 64'd0);
    chk("reset_wd", 64'(rf_wd), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_full", 64'(fpu_full), 64'd0);

    // FPU-only request on an empty queue goes straight to the port
    set_fpu(1'b1, 6'h21, 32'h3F800000, 15'h0100);
    rs1_q = 6'h21;
    #1 chk("direct_hit_fv", 64'(pend_hit1), 64'd1);
    tick();
    chk("direct_we", 64'(rf_we), 64'd1);
    chk("direct_rd", 64'(rf_rd), 64'h21);
    chk("direct_wd", 64'(rf_wd), 64'h3F800000);
    chk("direct_pc", 64'(rf_pc), 64'h0100);
    idle();
    rs1_q = 6'd0;
    tick();
    chk("direct_noenq_we", 64'(rf_we), 64'd0);

    // Main and FPU together: main first, FPU queued one cycle
    set_main(1'b1, 6'd5, 32'd7, 15'h0010);
    set_fpu(1'b1, 6'h22, 32'd9, 15'h0011);
    tick();
    chk("both_main_rd", 64'(rf_rd), 64'd5);
    chk("both_main_wd", 64'(rf_wd), 64'd7);
    idle();
    rs1_q = 6'h22;
    #1 chk("both_pend_hit1", 64'(pend_hit1), 64'd1);
    tick();
    chk("both_fpu_we", 64'(rf_we), 64'd1);
    chk("both_fpu_rd", 64'(rf_rd), 64'h22);
    chk("both_fpu_wd", 64'(rf_wd), 64'd9);
    chk("both_fpu_pc", 64'(rf_pc), 64'h0011);
    chk("both_hit_cleared", 64'(pend_hit1), 64'd0);
    tick();
    chk("both_idle_we", 64'(rf_we), 64'd0);

    // Queued f3 killed by a younger main write to the same Rd
    set_main(1'b1, 6'd1, 32'hA, 15'h001F);
    set_fpu(1'b1, 6'h23, 32'hC, 15'h0020);
    tick();
    chk("kill_m1_rd", 64'(rf_rd), 64'd1);
    set_main(1'b1, 6'h23, 32'hB, 15'h0021);
    set_fpu(1'b0, 6'd0, 32'd0, 15'd0);
    tick();
    chk("kill_main_rd", 64'(rf_rd), 64'h23);
    chk("kill_main_wd", 64'(rf_wd), 64'hB);
    idle();
    rs1_q = 6'h23;
    #1 chk("kill_dead_nohit", 64'(pend_hit1), 64'd0);
    tick();
    chk("kill_dead_pop_we", 64'(rf_we), 64'd0);
    tick();
    chk("kill_after_we", 64'(rf_we), 64'd0);
    rs1_q = 6'd0;

    // Six main cycles with FPU every cycle: fill, backpressure, overflow
    for (int k = 0; k < 6; k++) begin
      set_main(1'b1, 6'(k + 1), 32'(k + 32'h50), 15'(k));
      set_fpu(1'b1, 6'(6'h30 + k), 32'(32'h100 + k), 15'(15'h40 + k));
      tick();
      chk("ovf_main_rd", 64'(rf_rd), 64'(k + 1));
      if (k == 1) chk("ovf_full_c2", 64'(fpu_full), 64'd0);
      if (k == 2) chk("ovf_full_c3", 64'(fpu_full), 64'd1);
      if (k == 3) chk("ovf_flag_c4", 64'(overflow), 64'd0);
      if (k == 4) chk("ovf_flag_set", 64'(overflow), 64'd1);
    end
    idle();
    rs2_q = 6'h31;
    #1 chk("ovf_pend_hit2", 64'(pend_hit2), 64'd1);
    rs2_q = 6'h34;
    #1 chk("ovf_dropped_nohit", 64'(pend_hit2), 64'd0);
    rs2_q = 6'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_we", 64'(rf_we), 64'd1);
      chk("drain_rd", 64'(rf_rd), 64'(6'h30 + k));
      chk("drain_wd", 64'(rf_wd), 64'(32'h100 + k));
      if (k == 0) chk("drain_full_c3", 64'(fpu_full), 64'd1);
      if (k == 1) chk("drain_full_c2", 64'(fpu_full), 64'd0);
    end
    tick();
    chk("drain_done_we", 64'(rf_we), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Main request with Rd=0 is ignored; FPU goes direct
    set_main(1'b1, 6'd0, 32'hDEAD, 15'h0050);
    set_fpu(1'b1, 6'h24, 32'h55, 15'h0051);
    tick();
    chk("rd0_we", 64'(rf_we), 64'd1);
    chk("rd0_rd", 64'(rf_rd), 64'h24);
    chk("rd0_wd", 64'(rf_wd), 64'h55);
    idle();
    tick();
    chk("rd0_noenq_we", 64'(rf_we), 64'd0);

    // Reset with two entries queued
    set_main(1'b1, 6'd2, 32'h1, 15'h0060);
    set_fpu(1'b1, 6'h25, 32'h2, 15'h0061);
    tick();
    set_main(1'b1, 6'd3, 32'h3, 15'h0062);
    set_fpu(1'b1, 6'h26, 32'h4, 15'h0063);
    tick();
    idle();
    rs1_q = 6'h25;
    #1 chk("rst_pre_hit", 64'(pend_hit1), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_we", 64'(rf_we), 64'd0);
    chk("rst_hit_cleared", 64'(pend_hit1), 64'd0);
    chk("rst_ovf_cleared", 64'(overflow), 64'd0);
    chk("rst_full_cleared", 64'(fpu_full), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_post_we", 64'(rf_we), 64'd0);
    tick();
    chk("rst_post_we2", 64'(rf_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
